// File: rtl/fifo_flex.sv
// fifo_flex: synchronous FIFO, any depth >= 2, with an optional head output register (REG_OUT).
// Define FIFO_FLEX_ERR_EN to add the overflow_err / peak_count diagnostic outputs.
module fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int REG_OUT    = 0,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_valid,
  output logic                  write_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_valid,
  input  logic                  read_ready,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count
`ifdef FIFO_FLEX_ERR_EN
  ,
  output logic                  overflow_err,
  output logic [CNT_WIDTH-1:0]  peak_count
`endif
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_C     = CNT_WIDTH'(AF_THRESH);
  localparam logic [CNT_WIDTH-1:0] AE_C     = CNT_WIDTH'(AE_THRESH);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(FIFO_DEPTH - 1);

`ifndef SYNTHESIS
  if ((DATA_WIDTH < 1) || (FIFO_DEPTH < 2) || (AF_THRESH < 1) || (AF_THRESH > FIFO_DEPTH) ||
      (AE_THRESH < 0) || (AE_THRESH > FIFO_DEPTH - 1)) begin : g_param_chk
    $fatal(1, "fifo_flex: illegal parameter set");
  end
`endif

  // Depth need not be a power of two, so the wrap is explicit.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  full_q, empty_q, af_q, ae_q;
  logic                  wr_en_s, rd_en_s, mem_pop_s, read_valid_s;
  logic [DATA_WIDTH-1:0] head_s;

  assign wr_en_s = write_valid && !full_q;
  assign rd_en_s = read_valid_s && read_ready;

  if (REG_OUT != 0) begin : g_reg_out
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic [CNT_WIDTH-1:0]  mem_cnt_s;

    // count covers the output register word, so storage holds count minus that word.
    assign mem_cnt_s    = count_q - CNT_WIDTH'(out_valid_q);
    assign mem_pop_s    = (mem_cnt_s != '0) && (!out_valid_q || rd_en_s);
    assign read_valid_s = out_valid_q;
    assign head_s       = out_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid_q <= 1'b0;
        out_q       <= '0;
      end else if (flush) begin
        out_valid_q <= 1'b0;
      end else if (mem_pop_s) begin
        out_valid_q <= 1'b1;
        out_q       <= mem_q[rd_ptr_q];
      end else if (rd_en_s) begin
        out_valid_q <= 1'b0;
      end
    end
  end else begin : g_comb_out
    assign mem_pop_s    = rd_en_s;
    assign read_valid_s = !empty_q;
    assign head_s       = mem_q[rd_ptr_q];
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en_s)   wr_ptr_d = ptr_inc(wr_ptr_q);
      if (mem_pop_s) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_en_s, rd_en_s})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Status flags are registered alongside count, from its next value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= AF_C);
      ae_q     <= (count_d <= AE_C);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s && !flush) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign write_ready  = !full_q;
  assign read_valid   = read_valid_s;
  assign data_out     = read_valid_s ? head_s : '0;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;

`ifdef FIFO_FLEX_ERR_EN
  logic                 ovf_q;
  logic [CNT_WIDTH-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (flush) begin
      peak_d = '0;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end else begin
      peak_d = peak_q;
    end
  end

  // Overflow is sticky across flush; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      peak_q <= '0;
    end else begin
      if (write_valid && full_q) ovf_q <= 1'b1;
      peak_q <= peak_d;
    end
  end

  assign overflow_err = ovf_q;
  assign peak_count   = peak_q;
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex: depth-16 comb-out, depth-5 wrap, and depth-16 registered-out instances.
module tb_fifo_flex;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int bw = 1;
  int br = 1;
  int bcnt = 0;

  // Instance A: depth 16, REG_OUT=0, AF=14, AE=2
  logic       a_flush = 1'b0, a_wv = 1'b0, a_rr = 1'b0;
  logic [7:0] a_din = 8'h00, a_dout;
  logic       a_wr, a_rv, a_full, a_empty, a_af, a_ae;
  logic [4:0] a_count;
  // Instance B: depth 5, REG_OUT=0, AF=3, AE=2
  logic       b_flush = 1'b0, b_wv = 1'b0, b_rr = 1'b0;
  logic [7:0] b_din = 8'h00, b_dout;
  logic       b_wr, b_rv, b_full, b_empty, b_af, b_ae;
  logic [2:0] b_count;
  // Instance C: depth 16, REG_OUT=1
  logic       c_flush = 1'b0, c_wv = 1'b0, c_rr = 1'b0;
  logic [7:0] c_din = 8'h00, c_dout;
  logic       c_wr, c_rv, c_full, c_empty, c_af, c_ae;
  logic [4:0] c_count;
`ifdef FIFO_FLEX_ERR_EN
  logic       a_ovf, b_ovf, c_ovf;
  logic [4:0] a_peak, c_peak;
  logic [2:0] b_peak;
`endif

  fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .REG_OUT(0)) u_dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .data_in(a_din), .write_valid(a_wv),
    .write_ready(a_wr), .data_out(a_dout), .read_valid(a_rv), .read_ready(a_rr),
    .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .count(a_count)
`ifdef FIFO_FLEX_ERR_EN
    , .overflow_err(a_ovf), .peak_count(a_peak)
`endif
  );

  fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .REG_OUT(0)) u_dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .data_in(b_din), .write_valid(b_wv),
    .write_ready(b_wr), .data_out(b_dout), .read_valid(b_rv), .read_ready(b_rr),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .count(b_count)
`ifdef FIFO_FLEX_ERR_EN
    , .overflow_err(b_ovf), .peak_count(b_peak)
`endif
  );

  fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .REG_OUT(1)) u_dut_c (
    .clk(clk), .rst(rst), .flush(c_flush), .data_in(c_din), .write_valid(c_wv),
    .write_ready(c_wr), .data_out(c_dout), .read_valid(c_rv), .read_ready(c_rr),
    .full(c_full), .empty(c_empty), .almost_full(c_af), .almost_empty(c_ae), .count(c_count)
`ifdef FIFO_FLEX_ERR_EN
    , .overflow_err(c_ovf), .peak_count(c_peak)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on instance B against the bench's own write/read/occupancy counters.
  task automatic b_step(input logic w, input logic r);
    b_wv  = w;
    b_rr  = r;
    b_din = 8'(bw);
    if (r) begin
      check("b_rv", 32'(b_rv), 32'd1);
      check("b_data", 32'(b_dout), 32'(br & 8'hFF));
    end
    tick();
    if (w) bw++;
    if (r) br++;
    bcnt = bcnt + int'(w) - int'(r);
    check("b_count", 32'(b_count), 32'(bcnt));
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_empty", 32'(a_empty), 32'd1);
    check("rst_ae",    32'(a_ae),    32'd1);
    check("rst_full",  32'(a_full),  32'd0);
    check("rst_af",    32'(a_af),    32'd0);
    check("rst_rv",    32'(a_rv),    32'd0);
    check("rst_dout",  32'(a_dout),  32'd0);
    check("rst_wr",    32'(a_wr),    32'd1);
    check("rst_count", 32'(a_count), 32'd0);
    check("rst_c_rv",  32'(c_rv),    32'd0);
    check("rst_c_dout",32'(c_dout),  32'd0);
    tick();
    rst = 1'b0;
    tick();

    // A: fill 0x01..0x10, then drain in order
    for (int i = 1; i <= 16; i++) begin
      a_din = 8'(i);
      a_wv  = 1'b1;
      tick();
      if (i == 1) begin
        check("a_lat_rv",   32'(a_rv),   32'd1);
        check("a_lat_dout", 32'(a_dout), 32'h01);
      end
      check("a_fill_cnt",  32'(a_count), 32'(i));
      check("a_fill_full", 32'(a_full),  32'(i == 16));
      check("a_fill_wr",   32'(a_wr),    32'(i != 16));
      check("a_fill_af",   32'(a_af),    32'(i >= 14));
      check("a_fill_ae",   32'(a_ae),    32'(i <= 2));
    end
    a_din = 8'h99;
    tick();
    a_wv = 1'b0;
    check("a_ovr_cnt",  32'(a_count), 32'd16);
    check("a_ovr_head", 32'(a_dout),  32'h01);
    a_rr = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check("a_drain_rv",   32'(a_rv),   32'd1);
      check("a_drain_data", 32'(a_dout), 32'(i));
      tick();
    end
    a_rr = 1'b0;
    check("a_drain_empty", 32'(a_empty), 32'd1);
    check("a_drain_rv0",   32'(a_rv),    32'd0);
    check("a_drain_dout0", 32'(a_dout),  32'd0);

    // A: hold count at 8 with simultaneous write and read
    a_wv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_din = 8'(8'h20 + i);
      tick();
    end
    a_rr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a_din = 8'(8'h30 + k);
      check("a_sim_data", 32'(a_dout), (k < 8) ? 32'(8'h20 + k) : 32'(8'h30 + k - 8));
      tick();
      check("a_sim_cnt", 32'(a_count), 32'd8);
      check("a_sim_af",  32'(a_af),    32'd0);
      check("a_sim_ae",  32'(a_ae),    32'd0);
    end
    a_wv = 1'b0;
    check("a_rd_data0", 32'(a_dout), 32'h32);
    tick();
    check("a_rd_data1", 32'(a_dout), 32'h33);
    tick();
    a_rr = 1'b0;
    check("a_cnt6", 32'(a_count), 32'd6);

    // A: flush beats a concurrent write
    a_flush = 1'b1;
    a_wv    = 1'b1;
    a_din   = 8'hEE;
    tick();
    a_flush = 1'b0;
    a_wv    = 1'b0;
    check("a_fl_cnt",   32'(a_count), 32'd0);
    check("a_fl_empty", 32'(a_empty), 32'd1);
    check("a_fl_rv",    32'(a_rv),    32'd0);
    check("a_fl_dout",  32'(a_dout),  32'd0);
    a_din = 8'h42;
    a_wv  = 1'b1;
    tick();
    a_wv = 1'b0;
    check("a_postfl_head", 32'(a_dout),  32'h42);
    check("a_postfl_cnt",  32'(a_count), 32'd1);
    a_rr = 1'b1;
    tick();
    a_rr = 1'b0;

    // A: reset mid-transfer discards contents
    a_wv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_din = 8'(8'h61 + i);
      tick();
    end
    a_wv = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("a_mrst_cnt",   32'(a_count), 32'd0);
    check("a_mrst_empty", 32'(a_empty), 32'd1);
    check("a_mrst_dout",  32'(a_dout),  32'd0);
    tick();
    rst   = 1'b0;
    a_din = 8'h77;
    a_wv  = 1'b1;
    tick();
    a_wv = 1'b0;
    check("a_mrst_first", 32'(a_dout),  32'h77);
    check("a_mrst_cnt1",  32'(a_count), 32'd1);
    a_rr = 1'b1;
    tick();
    a_rr = 1'b0;

`ifdef FIFO_FLEX_ERR_EN
    check("err_ovf_clr", 32'(a_ovf), 32'd0);
    a_wv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_din = 8'(i);
      tick();
    end
    check("err_peak16", 32'(a_peak), 32'd16);
    check("err_ovf0",   32'(a_ovf),  32'd0);
    tick();
    a_wv = 1'b0;
    check("err_ovf1", 32'(a_ovf), 32'd1);
    a_rr = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    a_rr = 1'b0;
    check("err_ovf_sticky", 32'(a_ovf),  32'd1);
    check("err_peak_hold",  32'(a_peak), 32'd16);
    #2 rst = 1'b1;
    #1;
    check("err_ovf_rst",  32'(a_ovf),  32'd0);
    check("err_peak_rst", 32'(a_peak), 32'd0);
    tick();
    rst = 1'b0;
`endif

    // B: depth 5, fill to full, drain, then interleave so pointers wrap
    for (int i = 0; i < 5; i++) b_step(1'b1, 1'b0);
    check("b_full", 32'(b_full), 32'd1);
    check("b_wr0",  32'(b_wr),   32'd0);
    check("b_af",   32'(b_af),   32'd1);
    for (int i = 0; i < 5; i++) b_step(1'b0, 1'b1);
    check("b_empty", 32'(b_empty), 32'd1);
    for (int i = 0; i < 3; i++) b_step(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) b_step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) b_step(1'b0, 1'b1);
    b_wv = 1'b0;
    b_rr = 1'b0;
    check("b_end_empty", 32'(b_empty), 32'd1);
    check("b_end_rv",    32'(b_rv),    32'd0);

    // C: registered output, two-edge latency
    c_din = 8'hA5;
    c_wv  = 1'b1;
    tick();
    c_wv = 1'b0;
    check("c_lat_rv_n",   32'(c_rv),    32'd0);
    check("c_lat_dout_n", 32'(c_dout),  32'd0);
    check("c_lat_cnt_n",  32'(c_count), 32'd1);
    tick();
    check("c_lat_rv_n1",   32'(c_rv),    32'd1);
    check("c_lat_dout_n1", 32'(c_dout),  32'hA5);
    c_rr = 1'b1;
    tick();
    c_rr = 1'b0;
    check("c_rd_empty", 32'(c_empty), 32'd1);
    check("c_rd_rv",    32'(c_rv),    32'd0);

    // C: preload three, then stream one word per cycle
    c_wv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c_din = 8'(8'h50 + i);
      tick();
    end
    check("c_pre_rv",   32'(c_rv),    32'd1);
    check("c_pre_dout", 32'(c_dout),  32'h50);
    check("c_pre_cnt",  32'(c_count), 32'd3);
    c_rr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      c_din = 8'(8'h53 + k);
      check("c_str_rv",   32'(c_rv),   32'd1);
      check("c_str_data", 32'(c_dout), 32'(8'h50 + k));
      tick();
      check("c_str_cnt", 32'(c_count), 32'd3);
    end
    c_wv = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("c_tail_rv",   32'(c_rv),   32'd1);
      check("c_tail_data", 32'(c_dout), 32'(8'h5A + j));
      tick();
    end
    c_rr = 1'b0;
    check("c_tail_empty", 32'(c_empty), 32'd1);

    // C: capacity including the output register is 16
    c_wv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      c_din = 8'(8'h80 + i);
      tick();
    end
    c_wv = 1'b0;
    check("c_full",     32'(c_full),  32'd1);
    check("c_full_cnt", 32'(c_count), 32'd16);
    check("c_full_wr",  32'(c_wr),    32'd0);
    c_rr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("c_dr_rv",   32'(c_rv),   32'd1);
      check("c_dr_data", 32'(c_dout), 32'(8'h80 + i));
      tick();
    end
    c_rr = 1'b0;
    check("c_dr_empty", 32'(c_empty), 32'd1);
    check("c_dr_dout",  32'(c_dout),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_flex.md
FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 Parameter DATA_WIDTH, default 8: word width in bits, SHALL be >=1.
REQ-002 Parameter FIFO_DEPTH, default 16: capacity in words, SHALL be >=2, any integer (power of 2 not required).
REQ-003 Parameter REG_OUT, default 0: 0 = head word driven from storage, 1 = head word held in an output register.
REQ-004 Parameter AF_THRESH, default FIFO_DEPTH-2: almost_full level, SHALL be 1..FIFO_DEPTH.
REQ-005 Parameter AE_THRESH, default 2: almost_empty level, SHALL be 0..FIFO_DEPTH-1.
REQ-006 Localparam CNT_WIDTH = $clog2(FIFO_DEPTH+1).
REQ-007 Ports: one clock; reset is asynchronous and active-high.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst  in  1  async reset, active-high.
REQ-010 flush  in  1  synchronous clear of contents.
REQ-011 data_in  in  DATA_WIDTH  write word; write_valid in 1; write_ready out 1.
REQ-012 data_out  out  DATA_WIDTH  head word; read_valid out 1; read_ready in 1.
REQ-013 full, empty, almost_full, almost_empty  out  1  status; count  out  CNT_WIDTH  occupancy.

Function
REQ-014 Write accepted iff write_valid && write_ready; write_ready SHALL equal !full; no write pass-through when full.
REQ-015 Read accepted iff read_valid && read_ready; read_valid SHALL stay high and data_out stable until accepted.
REQ-016 data_out SHALL be all-zeros whenever read_valid is 0.
REQ-017 Write/read pointers SHALL wrap from FIFO_DEPTH-1 to 0 explicitly; no reliance on power-of-2 overflow.
REQ-018 count SHALL be registered: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-019 count SHALL include the output-register word when REG_OUT=1; total capacity is FIFO_DEPTH in both modes.
REQ-020 full = (count==FIFO_DEPTH); empty = (count==0); almost_full = (count>=AF_THRESH); almost_empty = (count<=AE_THRESH).
REQ-021 REG_OUT=0: write into empty FIFO at edge N SHALL give read_valid=1 after edge N (1-cycle latency).
REQ-022 REG_OUT=1: head loads the output register whenever it is empty or being read in the same cycle; write into empty FIFO at edge N SHALL give read_valid=1 after edge N+1.
REQ-023 REG_OUT=1: back-to-back reads with read_ready held high SHALL sustain one word per cycle without bubbles.
REQ-024 Word order SHALL be strict FIFO in both modes.
REQ-025 flush SHALL, at the next edge, set count=0 and clear pointers and read_valid; it overrides any write or read in that cycle; storage contents are not cleared.

Reset
REQ-026 rst high SHALL immediately clear pointers, count, output register valid, and error state: empty=1, almost_empty=1, full=0, almost_full=0 (when AF_THRESH>=1), read_valid=0, data_out=0, write_ready=1.
REQ-027 Storage array SHALL NOT be reset.
REQ-028 Reset asserted mid-transfer SHALL discard all contents; the first write after release SHALL be the first word read.

Configuration
REQ-029 Macro FIFO_FLEX_ERR_EN defined: add outputs overflow_err (1) and peak_count (CNT_WIDTH).
REQ-030 overflow_err: sticky, set when write_valid && full; cleared only by rst. peak_count: running maximum of count; cleared by rst and flush.
REQ-031 Macro undefined: those ports and their logic SHALL NOT exist; all other behaviour identical.
REQ-032 Simulation-only elaboration checks SHALL $fatal on DATA_WIDTH==0, FIFO_DEPTH<2, or thresholds out of range.

Verification
REQ-033 DEPTH=16, REG_OUT=0: write 0x01..0x10 with read_ready=0 -> full=1 after the 16th write, count=16, write_ready=0; drain -> 0x01..0x10 in order, then empty=1.
REQ-034 DEPTH=5: 12 writes and 12 reads interleaved -> pointers wrap twice, data in order, count never exceeds 5.
REQ-035 REG_OUT=1: single write 0xA5 at edge N -> read_valid=1 and data_out=0xA5 after edge N+1; with continuous streaming, one word per cycle.
REQ-036 count=8 with simultaneous write and read for 10 cycles -> count stays 8; almost flags unchanged (AF=14, AE=2).
REQ-037 count=6, flush and write_valid asserted together -> next cycle count=0, empty=1, read_valid=0; written word discarded.
REQ-038 FIFO_FLEX_ERR_EN defined: fill to 16, assert write_valid 1 cycle -> overflow_err=1 and stays set after drain; peak_count=16; rst clears both.
